bilinear_addr_sched: RTL and testbench

//  Sequencer for the bilinear scaler datapath. On a start request it derives output size and

---
 rtl/bilinear_addr_sched.sv | 196 +++++++++++++++++++
 tb/tb_bilinear_addr_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bilinear_addr_sched.sv
// Sequencer for the bilinear scaler: derives output geometry and source step, walks the output
// raster, reads the four source neighbours per pixel and hands bundles to the interpolator.
module bilinear_addr_sched #(
  parameter int AW   = 12,
  parameter int FRAC = 8
) (
  input  logic          clk_sys,
  input  logic          rst_sys,
  input  logic          start_pulse,
  input  logic [15:0]   cfg_in_w,
  input  logic [15:0]   cfg_in_h,
  input  logic [15:0]   cfg_scale_q88,
  output logic [AW-1:0] in_mem_raddr,
  input  logic [7:0]    in_mem_rdata,
  output logic          px_valid,
  input  logic          px_ready,
  output logic [31:0]   px_nbr,
  output logic [7:0]    px_fx,
  output logic [7:0]    px_fy,
  output logic [AW-1:0] px_out_addr,
  output logic          status_busy,
  output logic          status_done,
  output logic          status_err,
  output logic [31:0]   perf_mem_rd,
  output logic [31:0]   perf_px,
  output logic [2:0]    dbg_state
);

  // px_valid/px_ready: a bundle transfers on a cycle where both are high; once px_valid rises
  // it stays high and px_nbr/px_fx/px_fy/px_out_addr stay unchanged until that transfer.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DIV   = 3'd1,
    S_SETUP = 3'd2,
    S_RD    = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [63:0] MAX_PIX = 64'd1 << AW;
  localparam logic [AW:0] ONE_O   = 1;

  state_t state, state_nx;

  logic          start_q, start_edge, start_ok;
  logic [15:0]   in_w, in_h, scale, inv;
  logic [4:0]    div_cnt;
  logic [16:0]   rem, quo, rem_sh;
  logic          div_ge;
  logic [31:0]   prod_w, prod_h, ow, oh, area_i;
  logic [63:0]   area_o;
  logic          reject;
  logic [AW:0]   out_w, out_h, ox, oy;
  logic [31:0]   sx, sy, sx_int, sy_int, xlim, ylim, x0, x1, y0, y1, w32, row0, row1, addr_sum;
  logic [2:0]    rd_cnt;
  logic [AW-1:0] raddr_q, addr_sel;
  logic          accept, last_px;

  assign start_edge = start_pulse & ~start_q;
  assign start_ok   = start_edge && (state == S_IDLE || state == S_DONE);

  // Restoring division of 65536 by scale: the dividend's single 1 bit enters on the first step.
  assign rem_sh = (rem << 1) | {16'd0, div_cnt == 5'd0};
  assign div_ge = rem_sh >= {1'b0, scale};
  assign inv    = quo[16] ? 16'hFFFF : quo[15:0];

  assign prod_w = {16'd0, in_w} * {16'd0, scale};
  assign prod_h = {16'd0, in_h} * {16'd0, scale};
  assign ow     = prod_w >> FRAC;
  assign oh     = prod_h >> FRAC;
  assign area_i = {16'd0, in_w} * {16'd0, in_h};
  assign area_o = {32'd0, ow} * {32'd0, oh};
  assign reject = (in_w < 16'd2) || (in_h < 16'd2) || (ow == 32'd0) || (oh == 32'd0) ||
                  ({32'd0, area_i} > MAX_PIX) || (area_o > MAX_PIX);

  assign w32    = {16'd0, in_w};
  assign xlim   = w32 - 32'd1;
  assign ylim   = {16'd0, in_h} - 32'd1;
  assign sx_int = sx >> FRAC;
  assign sy_int = sy >> FRAC;
  assign x0     = (sx_int > xlim) ? xlim : sx_int;
  assign x1     = (x0 == xlim) ? xlim : x0 + 32'd1;
  assign y0     = (sy_int > ylim) ? ylim : sy_int;
  assign y1     = (y0 == ylim) ? ylim : y0 + 32'd1;
  assign row0   = y0 * w32;
  assign row1   = y1 * w32;

  always_comb begin
    addr_sum = row0 + x0;
    case (rd_cnt[1:0])
      2'd1:    addr_sum = row0 + x1;
      2'd2:    addr_sum = row1 + x0;
      2'd3:    addr_sum = row1 + x1;
      default: addr_sum = row0 + x0;
    endcase
  end
  assign addr_sel = AW'(addr_sum);

  // Outside the four issue cycles the BRAM address holds the last one issued.
  assign in_mem_raddr = (state == S_RD && rd_cnt < 3'd4) ? addr_sel : raddr_q;
  assign px_valid     = (state == S_EMIT);
  assign px_fx        = sx[FRAC-1:0];
  assign px_fy        = sy[FRAC-1:0];
  assign dbg_state    = state;
  assign accept       = px_valid && px_ready;
  assign last_px      = (ox == out_w - ONE_O) && (oy == out_h - ONE_O);

  always_ff @(posedge clk_sys) begin
    if (rst_sys) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_nx = (cfg_scale_q88 == 16'd0) ? S_DONE : S_DIV;
      S_DIV:          if (div_cnt == 5'd16) state_nx = S_SETUP;
      S_SETUP:        state_nx = reject ? S_DONE : S_RD;
      S_RD:           if (rd_cnt == 3'd4) state_nx = S_EMIT;
      S_EMIT:         if (accept) state_nx = last_px ? S_DONE : S_RD;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      start_q <= 1'b0;
      in_w <= '0; in_h <= '0; scale <= '0;
      div_cnt <= '0; rem <= '0; quo <= '0;
      out_w <= '0; out_h <= '0; ox <= '0; oy <= '0; sx <= '0; sy <= '0;
      rd_cnt <= '0; raddr_q <= '0; px_nbr <= '0; px_out_addr <= '0;
      status_busy <= 1'b0; status_done <= 1'b0; status_err <= 1'b0;
      perf_mem_rd <= '0; perf_px <= '0;
    end else begin
      start_q <= start_pulse;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            in_w <= cfg_in_w; in_h <= cfg_in_h; scale <= cfg_scale_q88;
            div_cnt <= '0; rem <= '0; quo <= '0;
            ox <= '0; oy <= '0; sx <= '0; sy <= '0; rd_cnt <= '0; px_out_addr <= '0;
            perf_mem_rd <= '0; perf_px <= '0;
            status_busy <= (cfg_scale_q88 != 16'd0);
            status_done <= (cfg_scale_q88 == 16'd0);
            status_err  <= (cfg_scale_q88 == 16'd0);
          end
        end
        S_DIV: begin
          rem     <= div_ge ? rem_sh - {1'b0, scale} : rem_sh;
          quo     <= (quo << 1) | {16'd0, div_ge};
          div_cnt <= div_cnt + 5'd1;
        end
        S_SETUP: begin
          out_w  <= (AW+1)'(ow);
          out_h  <= (AW+1)'(oh);
          rd_cnt <= '0;
          if (reject) begin
            status_busy <= 1'b0; status_done <= 1'b1; status_err <= 1'b1;
          end
        end
        S_RD: begin
          if (rd_cnt < 3'd4) begin
            raddr_q     <= addr_sel;
            perf_mem_rd <= perf_mem_rd + 32'd1;
          end
          case (rd_cnt)
            3'd1:    px_nbr[7:0]   <= in_mem_rdata;
            3'd2:    px_nbr[15:8]  <= in_mem_rdata;
            3'd3:    px_nbr[23:16] <= in_mem_rdata;
            3'd4:    px_nbr[31:24] <= in_mem_rdata;
            default: ;
          endcase
          rd_cnt <= (rd_cnt == 3'd4) ? 3'd0 : rd_cnt + 3'd1;
        end
        S_EMIT: begin
          if (accept) begin
            perf_px     <= perf_px + 32'd1;
            px_out_addr <= px_out_addr + AW'(1);
            if (ox == out_w - ONE_O) begin
              ox <= '0; sx <= '0;
              oy <= oy + ONE_O; sy <= sy + {16'd0, inv};
            end else begin
              ox <= ox + ONE_O; sx <= sx + {16'd0, inv};
            end
            if (last_px) begin
              status_busy <= 1'b0; status_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bilinear_addr_sched.sv
// Directed bench for bilinear_addr_sched: BRAM model, bundle monitor and hand-computed expectations.
module tb_bilinear_addr_sched;

  localparam int AW = 12;
  localparam int W  = 60;

  logic          clk_sys, rst_sys, start_pulse, px_ready, px_valid;
  logic [15:0]   cfg_in_w, cfg_in_h, cfg_scale_q88;
  logic [AW-1:0] in_mem_raddr, px_out_addr;
  logic [7:0]    in_mem_rdata, px_fx, px_fy;
  logic [31:0]   px_nbr, perf_mem_rd, perf_px;
  logic          status_busy, status_done, status_err;
  logic [2:0]    dbg_state;

  logic [7:0]    mem [0:4095];
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  got_q[$];
  int            n_total = 0;
  int            n_bad   = 0;

  bilinear_addr_sched #(.AW(AW), .FRAC(8)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .start_pulse(start_pulse),
    .cfg_in_w(cfg_in_w), .cfg_in_h(cfg_in_h), .cfg_scale_q88(cfg_scale_q88),
    .in_mem_raddr(in_mem_raddr), .in_mem_rdata(in_mem_rdata),
    .px_valid(px_valid), .px_ready(px_ready), .px_nbr(px_nbr),
    .px_fx(px_fx), .px_fy(px_fy), .px_out_addr(px_out_addr),
    .status_busy(status_busy), .status_done(status_done), .status_err(status_err),
    .perf_mem_rd(perf_mem_rd), .perf_px(perf_px), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // synchronous-read BRAM model
  always @(posedge clk_sys) in_mem_rdata <= mem[in_mem_raddr];

  // accepted-bundle monitor
  always @(posedge clk_sys)
    if (!rst_sys && px_valid && px_ready) got_q.push_back({px_out_addr, px_fy, px_fx, px_nbr});

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic load_ramp4();
    for (int i = 0; i < 4096; i++) mem[i] = (i < 16) ? 8'(i) : 8'h00;
  endtask

  task automatic start_run(input logic [15:0] w, input logic [15:0] h, input logic [15:0] s);
    @(negedge clk_sys);
    got_q.delete();
    cfg_in_w = w; cfg_in_h = h; cfg_scale_q88 = s;
    start_pulse = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    start_pulse = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (status_done !== 1'b1 && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq({tag, "_done"}, 64'(status_done), 64'd1);
  endtask

  // scoreboard for a 4x4 ramp at unit scale
  task automatic check_t1_bundles(input string tag);
    int x1, y1;
    logic [31:0] nbr;
    exp_q.delete();
    for (int oy = 0; oy < 4; oy++)
      for (int ox = 0; ox < 4; ox++) begin
        x1  = (ox < 3) ? ox + 1 : 3;
        y1  = (oy < 3) ? oy + 1 : 3;
        nbr = {8'(y1*4 + x1), 8'(y1*4 + ox), 8'(oy*4 + x1), 8'(oy*4 + ox)};
        exp_q.push_back({12'(oy*4 + ox), 16'h0000, nbr});
      end
    check_eq({tag, "_count"}, 64'(got_q.size()), 64'd16);
    for (int i = 0; i < 16 && got_q.size() > 0; i++)
      check_eq($sformatf("%s_px%0d", tag, i), 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
  endtask

  initial begin
    int n;
    rst_sys = 1'b1; start_pulse = 1'b0; px_ready = 1'b1;
    cfg_in_w = 16'd0; cfg_in_h = 16'd0; cfg_scale_q88 = 16'd0;
    load_ramp4();
    repeat (3) @(negedge clk_sys);
    rst_sys = 1'b0;
    @(negedge clk_sys);
    check_eq("rst_valid", 64'(px_valid), 64'd0);
    check_eq("rst_busy", 64'(status_busy), 64'd0);
    check_eq("rst_done", 64'(status_done), 64'd0);
    check_eq("rst_err", 64'(status_err), 64'd0);
    check_eq("rst_raddr", 64'(in_mem_raddr), 64'd0);
    check_eq("rst_perf_rd", 64'(perf_mem_rd), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'd0);

    // T1: 4x4 ramp, unit scale
    start_run(16'd4, 16'd4, 16'd256);
    check_eq("t1_busy", 64'(status_busy), 64'd1);
    wait_done("t1");
    check_eq("t1_busy_end", 64'(status_busy), 64'd0);
    check_eq("t1_err", 64'(status_err), 64'd0);
    check_eq("t1_perf_rd", 64'(perf_mem_rd), 64'd64);
    check_eq("t1_perf_px", 64'(perf_px), 64'd16);
    check_eq("t1_px3", 64'(got_q[3]), 64'h003000007070303);
    check_t1_bundles("t1");

    // T2: 2x2 upscale by 2
    mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
    start_run(16'd2, 16'd2, 16'd512);
    wait_done("t2");
    check_eq("t2_perf_px", 64'(perf_px), 64'd16);
    check_eq("t2_perf_rd", 64'(perf_mem_rd), 64'd64);
    check_eq("t2_count", 64'(got_q.size()), 64'd16);
    check_eq("t2_px0", 64'(got_q[0]), 64'h0000000281E140A);
    check_eq("t2_px1", 64'(got_q[1]), 64'h0010080281E140A);
    check_eq("t2_px2", 64'(got_q[2]), 64'h002000028281414);
    check_eq("t2_px4", 64'(got_q[4]), 64'h0048000281E140A);
    check_eq("t2_px5", 64'(got_q[5]), 64'h0058080281E140A);
    check_eq("t2_px15", 64'(got_q[15]), 64'h00F808028282828);

    // T3: stall at pixel 5
    load_ramp4();
    start_run(16'd4, 16'd4, 16'd256);
    n = 0;
    while (!(got_q.size() == 5 && px_valid === 1'b1) && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq("t3_reach_px5", 64'(got_q.size() == 5 && px_valid === 1'b1), 64'd1);
    px_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      check_eq($sformatf("t3_valid_%0d", i), 64'(px_valid), 64'd1);
      check_eq($sformatf("t3_nbr_%0d", i), 64'(px_nbr), 64'h0A090605);
      check_eq($sformatf("t3_oaddr_%0d", i), 64'(px_out_addr), 64'd5);
      check_eq($sformatf("t3_raddr_%0d", i), 64'(in_mem_raddr), 64'd10);
      check_eq($sformatf("t3_perf_rd_%0d", i), 64'(perf_mem_rd), 64'd24);
    end
    px_ready = 1'b1;
    wait_done("t3");
    check_eq("t3_perf_rd", 64'(perf_mem_rd), 64'd64);
    check_eq("t3_perf_px", 64'(perf_px), 64'd16);
    check_t1_bundles("t3");

    // T4: rejected configurations
    @(negedge clk_sys);
    cfg_in_w = 16'd4; cfg_in_h = 16'd4; cfg_scale_q88 = 16'd0;
    start_pulse = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    check_eq("t4_err", 64'(status_err), 64'd1);
    check_eq("t4_done", 64'(status_done), 64'd1);
    check_eq("t4_busy", 64'(status_busy), 64'd0);
    check_eq("t4_perf_rd", 64'(perf_mem_rd), 64'd0);
    check_eq("t4_state", 64'(dbg_state), 64'd5);
    start_pulse = 1'b0;
    start_run(16'd1, 16'd4, 16'd256);
    check_eq("t4b_err_cleared", 64'(status_err), 64'd0);
    wait_done("t4b");
    check_eq("t4b_err", 64'(status_err), 64'd1);
    check_eq("t4b_perf_rd", 64'(perf_mem_rd), 64'd0);
    check_eq("t4b_busy", 64'(status_busy), 64'd0);
    start_run(16'd64, 16'd64, 16'd512);
    wait_done("t4c");
    check_eq("t4c_err", 64'(status_err), 64'd1);

    // T5: reset during the reads of pixel 2
    start_run(16'd4, 16'd4, 16'd256);
    check_eq("t5_err_cleared", 64'(status_err), 64'd0);
    n = 0;
    while (perf_mem_rd !== 32'd9 && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq("t5_reach_px2", 64'(perf_mem_rd), 64'd9);
    rst_sys = 1'b1;
    @(negedge clk_sys);
    check_eq("t5_busy", 64'(status_busy), 64'd0);
    check_eq("t5_valid", 64'(px_valid), 64'd0);
    check_eq("t5_raddr", 64'(in_mem_raddr), 64'd0);
    check_eq("t5_perf_rd", 64'(perf_mem_rd), 64'd0);
    rst_sys = 1'b0;
    check_eq("t5_no_bundle", 64'(got_q.size()), 64'd2);
    start_run(16'd4, 16'd4, 16'd256);
    wait_done("t5");
    check_eq("t5_perf_rd_end", 64'(perf_mem_rd), 64'd64);
    check_eq("t5_perf_px_end", 64'(perf_px), 64'd16);
    check_t1_bundles("t5");

    // T6: start edge while busy is ignored; start after done restarts counters
    start_run(16'd4, 16'd4, 16'd256);
    n = 0;
    while (perf_px !== 32'd3 && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq("t6_reach_px3", 64'(perf_px), 64'd3);
    cfg_scale_q88 = 16'd512;
    start_pulse = 1'b1;
    repeat (2) @(negedge clk_sys);
    start_pulse = 1'b0;
    wait_done("t6");
    check_eq("t6_perf_px", 64'(perf_px), 64'd16);
    check_t1_bundles("t6");
    start_run(16'd4, 16'd4, 16'd256);
    check_eq("t6b_perf_rd0", 64'(perf_mem_rd), 64'd0);
    check_eq("t6b_perf_px0", 64'(perf_px), 64'd0);
    check_eq("t6b_busy", 64'(status_busy), 64'd1);
    check_eq("t6b_done_clr", 64'(status_done), 64'd0);
    wait_done("t6b");
    check_eq("t6b_perf_rd", 64'(perf_mem_rd), 64'd64);
    check_eq("t6b_perf_px", 64'(perf_px), 64'd16);
    check_t1_bundles("t6b");

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
